// File: rtl/instr_dcd.sv
// rtl/instr_dcd.sv - SPI 2-byte frame decoder to register file pulses (define INSTR_DCD_AUTOINC_EN for burst mode)
module instr_dcd #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read
);

  typedef enum logic {S_CMD, S_DATA} state_t;

  state_t              state, state_nxt;
  logic                rw, rw_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_write_nxt;
  logic                read_nxt, write_nxt;
  logic                cap;
`ifdef INSTR_DCD_AUTOINC_EN
  logic                inc_pend, inc_pend_nxt;
  logic                rd_pend, rd_pend_nxt;
`endif

  // Frame state, latched command fields and single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CMD;
      rw         <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
`ifdef INSTR_DCD_AUTOINC_EN
      inc_pend   <= 1'b0;
      rd_pend    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      rw         <= rw_nxt;
      addr       <= addr_nxt;
      data_write <= data_write_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
`ifdef INSTR_DCD_AUTOINC_EN
      inc_pend   <= inc_pend_nxt;
      rd_pend    <= rd_pend_nxt;
`endif
    end
  end

  // Next-state decode: command byte sets address/direction, data byte fires the write
  always_comb begin
    state_nxt      = state;
    rw_nxt         = rw;
    addr_nxt       = addr;
    data_write_nxt = data_write;
    read_nxt       = 1'b0;
    write_nxt      = 1'b0;
`ifdef INSTR_DCD_AUTOINC_EN
    inc_pend_nxt   = 1'b0;
    rd_pend_nxt    = 1'b0;
    // Burst address advance: after a write pulse, or one cycle after a read data byte
    if (write) begin
      addr_nxt = addr + 1'b1;
    end
    if (inc_pend) begin
      addr_nxt    = addr + 1'b1;
      rd_pend_nxt = 1'b1;
    end
    if (rd_pend) begin
      read_nxt = 1'b1;
    end
`endif
    if (cs_n) begin
      // Deselect aborts any partial frame; registered pulses still finish
      state_nxt = S_CMD;
    end else if (byte_sync) begin
      case (state)
        S_CMD: begin
          addr_nxt  = data_in[ADDR_W-1:0];
          rw_nxt    = data_in[DATA_W-1];
          read_nxt  = ~data_in[DATA_W-1];
          state_nxt = S_DATA;
        end
        S_DATA: begin
          if (rw) begin
            data_write_nxt = data_in;
            write_nxt      = 1'b1;
          end
`ifdef INSTR_DCD_AUTOINC_EN
          else begin
            inc_pend_nxt = 1'b1;
          end
          state_nxt = S_DATA;
`else
          state_nxt = S_CMD;
`endif
        end
        default: state_nxt = S_CMD;
      endcase
    end
  end

  // Read data arrives one cycle after the read pulse; capture it then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap      <= 1'b0;
      data_out <= '0;
    end else begin
      cap <= read;
      if (cap) begin
        data_out <= data_read;
      end
    end
  end

endmodule

// File: tb/tb_instr_dcd.sv
// tb/tb_instr_dcd.sv - self-checking bench for instr_dcd with register file and scoreboard models
module tb_instr_dcd;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_write;
  logic [7:0] data_read = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem     [14] = '{default: 8'h00};
  logic [7:0] exp_mem [14] = '{default: 8'h00};

  instr_dcd #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_write (data_write),
    .data_read  (data_read)
  );

  always #5 clk = ~clk;

  // Register file model: 14 registers, upper addresses ignore writes and read as 0
  always @(posedge clk) begin
    if (write && addr < 6'd14) mem[addr] <= data_write;
    if (read) data_read <= (addr < 6'd14) ? mem[addr] : 8'h00;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [5:0] a);
    return (a < 6'd14) ? exp_mem[a] : 8'h00;
  endfunction

  task automatic send(input logic [7:0] b, input logic cs);
    data_in   = b;
    byte_sync = 1'b1;
    cs_n      = cs;
    @(negedge clk);
    byte_sync = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] dat);
    logic [5:0] a;
    logic       rd;
    a  = cmd[5:0];
    rd = ~cmd[7];
    send(cmd, 1'b0);
    chk("cmd_read", read, rd);
    chk("cmd_write", write, 0);
    chk("cmd_addr", addr, a);
    @(negedge clk);
    chk("cmd_read_end", read, 0);
    @(negedge clk);
    if (rd) chk("read_data", data_out, ref_rd(a));
    send(dat, 1'b0);
    chk("dat_write", write, !rd);
    chk("dat_read", read, 0);
    chk("dat_addr", addr, a);
    if (!rd) chk("dat_wdata", data_write, dat);
    @(negedge clk);
    chk("dat_write_end", write, 0);
    if (!rd && a < 6'd14) exp_mem[a] = dat;
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  initial begin
    logic [7:0] c, d;
    @(negedge clk);
    @(negedge clk);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", data_write, 0);
    chk("rst_dout", data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);

    frame(8'h80, 8'h34);
    frame(8'h88, 8'h5A);
    frame(8'h08, 8'h00);
    chk("t2_dout", data_out, 8'h5A);
    frame(8'hC5, 8'hFF);
    frame(8'h05, 8'h00);

    send(8'h81, 1'b0);
    chk("abort_cmd_write", write, 0);
    chk("abort_cmd_addr", addr, 6'h01);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    chk("abort_write", write, 0);
    cs_n = 1'b0;
    @(negedge clk);
    frame(8'h02, 8'h77);

    send(8'h85, 1'b1);
    chk("csn_wins_read", read, 0);
    chk("csn_wins_write", write, 0);
    chk("csn_wins_addr", addr, 6'h02);
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
    frame(8'h03, 8'h00);

    send(8'h08, 1'b0);
    chk("t5_read", read, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_read_rst", read, 0);
    chk("t5_addr_rst", addr, 0);
    chk("t5_dout_rst", data_out, 0);
    chk("t5_wdata_rst", data_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8'h08, 8'h00);

    frame(8'hBE, 8'h99);
    frame(8'h3E, 8'h00);
    chk("hi_addr_dout", data_out, 8'h00);

    for (int i = 0; i < 40; i++) begin
      c = 8'($urandom);
      d = 8'($urandom);
      if (i % 2 == 0) c[5:0] = 6'($urandom_range(0, 13));
      frame(c, d);
    end

`ifdef INSTR_DCD_AUTOINC_EN
    send(8'hBF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    send(8'h11, 1'b0);
    chk("burst_w1", write, 1);
    chk("burst_a1", addr, 6'h3F);
    chk("burst_d1", data_write, 8'h11);
    @(negedge clk);
    @(negedge clk);
    send(8'h22, 1'b0);
    chk("burst_w2", write, 1);
    chk("burst_a2", addr, 6'h00);
    chk("burst_d2", data_write, 8'h22);
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
